// File: rtl/ppe_row_conv_if.sv
`default_nettype none
// ============================================================================
// Module   : ppe_row_conv_if
// Brief    : Router-facing packet links of the row-convolution PPE: an ingress
//            valid/ready port and an egress valid/ready port, 33-bit packets.
// Revision : 1.0 - initial release
// ============================================================================
interface ppe_row_conv_if #(
    parameter int PKT_WIDTH = 33
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PKT_WIDTH-1:0] in_packet;
    logic                 out_valid;
    logic                 out_ready;
    logic [PKT_WIDTH-1:0] out_packet;

    // PPE side
    modport slave (
        input  in_valid, in_packet, out_ready,
        output in_ready, out_valid, out_packet
    );

    // Router side
    modport master (
        output in_valid, in_packet, out_ready,
        input  in_ready, out_valid, out_packet
    );
endinterface
`default_nettype wire

// File: rtl/ppe_row_conv.sv
`default_nettype none
// ============================================================================
// Module   : ppe_row_conv
// Brief    : Holds one 5-tap weight row and convolves it over 25-bit spike
//            rows, emitting one partial-sum packet per output position.
// Revision : 1.0 - initial release
// ============================================================================
module ppe_row_conv #(
    parameter logic [3:0] PE_ID        = 4'd5,
    parameter logic [3:0] PSUM_DEST    = 4'd12,
    parameter int         FILTER_SIZE  = 5,
    parameter int         IFMAP_SIZE   = 25,
    parameter int         OUTPUT_SIZE  = 21,
    parameter int         WEIGHT_WIDTH = 8,
    parameter int         SUM_WIDTH    = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    ppe_row_conv_if.slave     bus,
    output logic              weights_loaded,
    output logic              ts_done
);
    localparam logic [3:0] OP_WEIGHT  = 4'd0;
    localparam logic [3:0] OP_INPUT   = 4'd1;
    localparam logic [3:0] OP_PSUM    = 4'd2;
    localparam logic [3:0] OP_TS_DONE = 4'd15;
    localparam int         IDX_W      = 5;
    localparam int         PAD_W      = IFMAP_SIZE - IDX_W - SUM_WIDTH;
    localparam logic [IDX_W-1:0] J_LAST = IDX_W'(OUTPUT_SIZE - 1);

    typedef enum logic [1:0] {
        ST_W0  = 2'd0,
        ST_W1  = 2'd1,
        ST_RDY = 2'd2,
        ST_OUT = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [WEIGHT_WIDTH-1:0]       w_q [FILTER_SIZE];
    logic [WEIGHT_WIDTH-1:0]       w_d [FILTER_SIZE];
    logic [IFMAP_SIZE-1:0]         spikes_q, spikes_d;
    logic [IDX_W-1:0]              j_q, j_d;
    logic                          out_valid_q, out_valid_d;
    logic [IFMAP_SIZE+7:0]         out_packet_q, out_packet_d;
    logic                          loaded_q, loaded_d;
    logic                          ts_done_q, ts_done_d;

    logic [3:0]                    pkt_dest;
    logic [3:0]                    pkt_op;
    logic [IFMAP_SIZE-1:0]         pkt_data;
    logic                          accept;
    logic                          mine;
    logic [IFMAP_SIZE-1:0]         psum_src;
    logic [IDX_W-1:0]              psum_idx;
    logic [FILTER_SIZE-1:0]        window;
    logic [SUM_WIDTH-1:0]          psum;
    logic [IFMAP_SIZE+7:0]         psum_packet;

    assign pkt_dest = bus.in_packet[IFMAP_SIZE+7 -: 4];
    assign pkt_op   = bus.in_packet[IFMAP_SIZE+3 -: 4];
    assign pkt_data = bus.in_packet[IFMAP_SIZE-1:0];
    assign accept   = bus.in_valid && bus.in_ready;
    assign mine     = accept && (pkt_dest == PE_ID);

    // One shared MAC: position 0 of a freshly accepted row, or the next
    // position of the row currently being streamed out.
    assign psum_src = (state_q == ST_OUT) ? spikes_q : pkt_data;
    assign psum_idx = (state_q == ST_OUT) ? (j_q + IDX_W'(1)) : '0;
    assign window   = FILTER_SIZE'(psum_src >> psum_idx);

    always_comb begin
        psum = '0;
        for (int k = 0; k < FILTER_SIZE; k++) begin
            if (window[k]) begin
                psum = psum + SUM_WIDTH'(w_q[k]);
            end
        end
    end

    assign psum_packet = {PSUM_DEST, OP_PSUM, psum_idx, {PAD_W{1'b0}}, psum};

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        spikes_d     = spikes_q;
        j_d          = j_q;
        out_valid_d  = out_valid_q;
        out_packet_d = out_packet_q;
        loaded_d     = loaded_q;
        ts_done_d    = 1'b0;

        case (state_q)
            ST_W0: begin
                if (mine && pkt_op == OP_WEIGHT) begin
                    w_d[0]  = pkt_data[7:0];
                    w_d[1]  = pkt_data[15:8];
                    w_d[2]  = pkt_data[23:16];
                    state_d = ST_W1;
                end
            end
            ST_W1: begin
                if (mine && pkt_op == OP_WEIGHT) begin
                    w_d[3]   = pkt_data[7:0];
                    w_d[4]   = pkt_data[15:8];
                    loaded_d = 1'b1;
                    state_d  = ST_RDY;
                end
            end
            ST_RDY: begin
                if (mine && pkt_op == OP_INPUT) begin
                    spikes_d     = pkt_data;
                    j_d          = '0;
                    out_valid_d  = 1'b1;
                    out_packet_d = psum_packet;
                    state_d      = ST_OUT;
                end else if (mine && pkt_op == OP_WEIGHT) begin
                    loaded_d = 1'b0;
                    w_d[0]   = pkt_data[7:0];
                    w_d[1]   = pkt_data[15:8];
                    w_d[2]   = pkt_data[23:16];
                    state_d  = ST_W1;
                end
            end
            ST_OUT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (j_q == J_LAST) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_RDY;
                    end else begin
                        j_d          = j_q + IDX_W'(1);
                        out_packet_d = psum_packet;
                    end
                end
            end
            default: state_d = ST_W0;
        endcase

        if (mine && pkt_op == OP_TS_DONE && state_q != ST_OUT) begin
            ts_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_W0;
            for (int k = 0; k < FILTER_SIZE; k++) begin
                w_q[k] <= '0;
            end
            spikes_q     <= '0;
            j_q          <= '0;
            out_valid_q  <= 1'b0;
            out_packet_q <= '0;
            loaded_q     <= 1'b0;
            ts_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            spikes_q     <= spikes_d;
            j_q          <= j_d;
            out_valid_q  <= out_valid_d;
            out_packet_q <= out_packet_d;
            loaded_q     <= loaded_d;
            ts_done_q    <= ts_done_d;
        end
    end

    assign bus.in_ready   = (state_q != ST_OUT);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_packet = out_packet_q;
    assign weights_loaded = loaded_q;
    assign ts_done        = ts_done_q;
endmodule
`default_nettype wire

// File: tb/tb_ppe_row_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppe_row_conv
// Brief    : Self-checking bench for ppe_row_conv: table vectors, corner-case
//            sequences and randomized rows against a convolution model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppe_row_conv;
    localparam logic [3:0] PE_ID     = 4'd5;
    localparam logic [3:0] PSUM_DEST = 4'd12;
    localparam int         N_OUT     = 21;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic weights_loaded;
    logic ts_done;

    ppe_row_conv_if bus ();

    ppe_row_conv #(
        .PE_ID     (PE_ID),
        .PSUM_DEST (PSUM_DEST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .weights_loaded (weights_loaded),
        .ts_done        (ts_done)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [39:0] w;
        logic [24:0] s;
        int          mode;
        int          e0;
        int          e4;
        int          etot;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Convolution straight from its definition: sum of w[k]*s[j+k].
    function automatic int ref_psum(input logic [39:0] w, input logic [24:0] s, input int j);
        int acc = 0;
        for (int k = 0; k < 5; k++) begin
            acc += int'(w[8*k +: 8]) * int'(s[j+k]);
        end
        return acc;
    endfunction

    // Tasks enter and leave on a falling edge.
    task automatic send(input logic [3:0] dest, input logic [3:0] op, input logic [24:0] data);
        int budget = 0;
        bus.in_valid  = 1'b1;
        bus.in_packet = {dest, op, data};
        while (!bus.in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic load_weights(input logic [39:0] w);
        send(PE_ID, 4'd0, {1'b0, w[23:0]});
        chk("wl_after_first", 64'(weights_loaded), 64'd0);
        send(PE_ID, 4'd0, {9'd0, w[39:24]});
        chk("wl_after_second", 64'(weights_loaded), 64'd1);
    endtask

    // mode 0: always ready, 1: ready every other cycle, 2: random ready
    task automatic collect(input logic [39:0] w, input logic [24:0] s, input int mode,
                           output int p0, output int p4, output int total);
        int          got     = 0;
        int          cyc     = 0;
        logic        stalled = 1'b0;
        logic [32:0] held    = '0;
        logic        ready;
        p0 = -1; p4 = -1; total = 0;
        chk("first_latency", 64'(bus.out_valid), 64'd1);
        while (got < N_OUT && cyc < 400) begin
            if (stalled) begin
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_hold", 64'(bus.out_packet), 64'(held));
            end
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cyc % 2 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = ready;
            if (bus.out_valid) begin
                if (ready) begin
                    chk("psum_packet", 64'(bus.out_packet),
                        64'({PSUM_DEST, 4'd2, 5'(got), 7'd0, 13'(ref_psum(w, s, got))}));
                    if (got == 0) p0 = int'(bus.out_packet[12:0]);
                    if (got == 4) p4 = int'(bus.out_packet[12:0]);
                    total += int'(bus.out_packet[12:0]);
                    got++;
                end
                stalled = !ready;
                held    = bus.out_packet;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        if (got < N_OUT) begin
            n_cmp++;
            n_fail++;
            $display("FAIL row_timeout: got %0d packets, expected %0d", got, N_OUT);
        end
        chk("row_end_valid", 64'(bus.out_valid), 64'd0);
        chk("row_end_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_row(input logic [39:0] w, input logic [24:0] s, input int mode,
                           input bit load, output int p0, output int p4, output int total);
        if (load) load_weights(w);
        send(PE_ID, 4'd1, s);
        collect(w, s, mode, p0, p4, total);
    endtask

    initial begin
        int          p0, p4, tot;
        logic [39:0] w_last;
        logic [39:0] rw;
        logic [24:0] rs;

        bus.in_valid  = 1'b0;
        bus.in_packet = '0;
        bus.out_ready = 1'b0;

        tbl[0] = '{40'h0504030201, 25'h1FFFFFF, 0, 15, 15, 315};
        tbl[1] = '{40'h0504030201, 25'h0000010, 0, 5, 1, 15};
        tbl[2] = '{40'hFFFFFFFFFF, 25'h1FFFFFF, 1, 1275, 1275, 26775};
        tbl[3] = '{40'h0504030201, 25'h0000001, 2, 1, 0, 1};
        tbl[4] = '{40'h0504030201, 25'h1000000, 0, 0, 0, 5};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_wl", 64'(weights_loaded), 64'd0);
        chk("rst_ts_done", 64'(ts_done), 64'd0);
        chk("rst_out_packet", 64'(bus.out_packet), 64'd0);

        // Foreign dest in W0 is dropped; state must still be W0
        send(4'd3, 4'd0, 25'h030201);
        chk("foreign_wl", 64'(weights_loaded), 64'd0);
        send(PE_ID, 4'd0, 25'h030201);
        chk("w0_to_w1_wl", 64'(weights_loaded), 64'd0);
        // OP_INPUT in W1 is dropped
        send(PE_ID, 4'd1, 25'h1FFFFFF);
        for (int i = 0; i < 3; i++) begin
            chk("w1_input_dropped", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
        end
        send(PE_ID, 4'd0, 25'h000504);
        chk("w1_to_rdy_wl", 64'(weights_loaded), 64'd1);
        // Unknown opcode and foreign input in RDY are dropped
        send(PE_ID, 4'd7, 25'h1FFFFFF);
        chk("bad_op_valid", 64'(bus.out_valid), 64'd0);
        send(4'd3, 4'd1, 25'h1FFFFFF);
        chk("foreign_input_valid", 64'(bus.out_valid), 64'd0);
        chk("foreign_input_ready", 64'(bus.in_ready), 64'd1);

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            run_row(tbl[i].w, tbl[i].s, tbl[i].mode, 1'b1, p0, p4, tot);
            chk("tbl_psum0", 64'(p0), 64'(tbl[i].e0));
            chk("tbl_psum4", 64'(p4), 64'(tbl[i].e4));
            chk("tbl_total", 64'(tot), 64'(tbl[i].etot));
        end
        w_last = tbl[4].w;

        // Timestep done in RDY: one-cycle pulse, weights retained
        send(PE_ID, 4'd15, 25'd0);
        chk("ts_pulse_hi", 64'(ts_done), 64'd1);
        @(negedge clk);
        chk("ts_pulse_lo", 64'(ts_done), 64'd0);
        chk("ts_wl_kept", 64'(weights_loaded), 64'd1);
        run_row(w_last, 25'h0A5A5A5, 0, 1'b0, p0, p4, tot);

        // Reset mid-row at j=10
        load_weights(40'h0504030201);
        send(PE_ID, 4'd1, 25'h1FFFFFF);
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_row_j", 64'(bus.out_packet[24:20]), 64'd10);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_wl", 64'(weights_loaded), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
        send(PE_ID, 4'd0, 25'h030201);
        chk("post_rst_w0", 64'(weights_loaded), 64'd0);
        send(PE_ID, 4'd15, 25'd0);
        chk("ts_in_w1", 64'(ts_done), 64'd1);
        send(PE_ID, 4'd0, 25'h000504);
        chk("post_rst_loaded", 64'(weights_loaded), 64'd1);

        // Randomized rows against the model
        for (int r = 0; r < 8; r++) begin
            rw = {8'($urandom), 32'($urandom)};
            rs = 25'($urandom);
            run_row(rw, rs, int'($urandom_range(0, 2)), 1'b1, p0, p4, tot);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
